// File: rtl/ecc_58_rd_check.sv
// Read-side ECC check stage: registers decoder output into a 2-entry skid buffer,
// counts single/double-bit errors, logs the first error address and raises sticky irqs.
module ecc_58_rd_check #(
  parameter int DATA_WIDTH = 58,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_poison,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  err_log_vld,
  output logic [ADDR_WIDTH-1:0] err_log_addr,
  output logic                  err_log_dbit,
  output logic                  irq_sbit,
  output logic                  irq_dbit
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state, state_next;
  logic                    accept, send;
  logic                    load_out, load_skid, out_from_skid;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic                    skid_poison;
  logic                    is_sbit, is_dbit;

  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;
  assign out_valid = (state != EMPTY);

  // A beat with both flags set is uncorrectable, so it only counts as dbit.
  assign is_dbit = accept & in_dbit_err;
  assign is_sbit = accept & in_sbit_err & ~in_dbit_err;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_out   = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && !send) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (!accept && send) begin
          state_next = EMPTY;
        end else if (accept && send) begin
          load_out = 1'b1;
        end
      end
      TWO: begin
        if (send) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_next    = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != TWO);
    end
  end

  // NOTE: the data registers are reset as well, because every output must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_poison  <= 1'b0;
      skid_data   <= '0;
      skid_poison <= 1'b0;
    end else begin
      if (load_out) begin
        out_data   <= out_from_skid ? skid_data   : in_data;
        out_poison <= out_from_skid ? skid_poison : in_dbit_err;
      end
      if (load_skid) begin
        skid_data   <= in_data;
        skid_poison <= in_dbit_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else begin
      if (clr)
        sbit_cnt <= is_sbit ? CNT_WIDTH'(1) : '0;
      else if (is_sbit && sbit_cnt != CNT_MAX)
        sbit_cnt <= sbit_cnt + 1'b1;

      if (clr)
        dbit_cnt <= is_dbit ? CNT_WIDTH'(1) : '0;
      else if (is_dbit && dbit_cnt != CNT_MAX)
        dbit_cnt <= dbit_cnt + 1'b1;
    end
  end

  // The log captures the first error and may upgrade once to a dbit, then freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_log_vld  <= 1'b0;
      err_log_addr <= '0;
      err_log_dbit <= 1'b0;
      irq_sbit     <= 1'b0;
      irq_dbit     <= 1'b0;
    end else begin
      if (clr) begin
        err_log_vld  <= is_sbit | is_dbit;
        err_log_addr <= (is_sbit | is_dbit) ? in_addr : '0;
        err_log_dbit <= is_dbit;
      end else if ((is_sbit || is_dbit) && !err_log_vld) begin
        err_log_vld  <= 1'b1;
        err_log_addr <= in_addr;
        err_log_dbit <= is_dbit;
      end else if (is_dbit && !err_log_dbit) begin
        err_log_addr <= in_addr;
        err_log_dbit <= 1'b1;
      end

      irq_sbit <= clr ? is_sbit : (irq_sbit | is_sbit);
      irq_dbit <= clr ? is_dbit : (irq_dbit | is_dbit);
    end
  end

endmodule

// File: tb/tb_ecc_58_rd_check.sv
// Randomized and directed bench for ecc_58_rd_check against a queue-based reference model.
module tb_ecc_58_rd_check;

  localparam int DW = 58;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          in_sbit_err, in_dbit_err;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_poison;
  logic          clr;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic          err_log_vld;
  logic [AW-1:0] err_log_addr;
  logic          err_log_dbit;
  logic          irq_sbit, irq_dbit;

  ecc_58_rd_check #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_poison(out_poison),
    .clr(clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .err_log_vld(err_log_vld), .err_log_addr(err_log_addr), .err_log_dbit(err_log_dbit),
    .irq_sbit(irq_sbit), .irq_dbit(irq_dbit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            poison;
  } word_t;

  word_t         q[$];
  int            m_s, m_d;
  bit            m_lv, m_ld, m_is, m_id, m_ready;
  logic [AW-1:0] m_la;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_s = 0; m_d = 0; m_lv = 0; m_ld = 0; m_la = '0; m_is = 0; m_id = 0; m_ready = 0;
  endtask

  task automatic model_update(input bit acc, input bit snd);
    bit e_d, e_s;
    word_t w;
    e_d = acc && in_dbit_err;
    e_s = acc && in_sbit_err && !in_dbit_err;
    if (snd) void'(q.pop_front());
    if (acc) begin
      w.data = in_data; w.poison = in_dbit_err;
      q.push_back(w);
    end
    if (clr) begin
      m_s = e_s ? 1 : 0;
      m_d = e_d ? 1 : 0;
      m_lv = e_s || e_d; m_ld = e_d; m_la = (e_s || e_d) ? in_addr : '0;
      m_is = e_s; m_id = e_d;
    end else begin
      if (e_s) m_s = (m_s + 1 > CMAX) ? CMAX : m_s + 1;
      if (e_d) m_d = (m_d + 1 > CMAX) ? CMAX : m_d + 1;
      if ((e_s || e_d) && !m_lv) begin
        m_lv = 1; m_ld = e_d; m_la = in_addr;
      end else if (e_d && !m_ld) begin
        m_ld = 1; m_la = in_addr;
      end
      m_is = m_is || e_s;
      m_id = m_id || e_d;
    end
    m_ready = (q.size() < 2);
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].data);
      check("out_poison", out_poison, q[0].poison);
    end
    check("sbit_cnt", sbit_cnt, m_s);
    check("dbit_cnt", dbit_cnt, m_d);
    check("err_log_vld", err_log_vld, m_lv);
    check("err_log_addr", err_log_addr, m_la);
    check("err_log_dbit", err_log_dbit, m_ld);
    check("irq_sbit", irq_sbit, m_is);
    check("irq_dbit", irq_dbit, m_id);
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic step(output bit acc);
    bit snd;
    @(negedge clk);
    compare_all();
    acc = in_valid && m_ready;
    snd = (q.size() > 0) && out_ready;
    @(posedge clk);
    model_update(acc, snd);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic set_in(input logic [DW-1:0] d, input logic [AW-1:0] a,
                        input bit s, input bit db, input bit c);
    in_valid = 1'b1; in_data = d; in_addr = a;
    in_sbit_err = s; in_dbit_err = db; clr = c;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0; clr = 1'b0;
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input logic [AW-1:0] a,
                            input bit s, input bit db, input bit c);
    bit acc;
    int n;
    set_in(d, a, s, db, c);
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    clear_in();
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    bit acc;
    rst = 1'b0; out_ready = 1'b1; in_data = '0; in_addr = '0;
    clear_in();
    model_clear();
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_irq", {irq_sbit, irq_dbit, err_log_vld}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Clean stream with downstream always ready.
    for (int i = 0; i < 4; i++) drive_word(rand_data(), AW'(i), 0, 0, 0);
    idle(2);

    // Backpressure: two words fill the buffer, the third waits upstream.
    out_ready = 1'b0;
    drive_word(58'h1111, 8'h01, 0, 0, 0);
    drive_word(58'h2222, 8'h02, 0, 0, 0);
    set_in(58'h3333, 8'h03, 0, 0, 0);
    idle(3);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_data", out_data, 58'h1111);
    out_ready = 1'b1;
    acc = 0;
    for (int n = 0; n < 10 && !acc; n++) step(acc);
    if (!acc) check("third_accept_timeout", 1'b0, 1'b1);
    clear_in();
    idle(4);
    check("drained", out_valid, 1'b0);

    // Error classes, log upgrade and freeze.
    drive_word(rand_data(), 8'h12, 1, 0, 0);
    drive_word(rand_data(), 8'h34, 0, 1, 0);
    drive_word(rand_data(), 8'h56, 0, 1, 0);
    idle(1);
    check("t3_sbit_cnt", sbit_cnt, 1);
    check("t3_dbit_cnt", dbit_cnt, 2);
    check("t3_log_addr", err_log_addr, 8'h34);
    check("t3_log_dbit", err_log_dbit, 1'b1);
    check("t3_irqs", {irq_sbit, irq_dbit}, 2'b11);

    // Both flags: counts as dbit only.
    drive_word(58'h3ff_0000_0000_0001, 8'h60, 1, 1, 0);
    check("both_poison", out_poison, 1'b1);
    idle(1);
    check("both_dbit_cnt", dbit_cnt, 3);
    check("both_sbit_cnt", sbit_cnt, 1);

    // Saturation, then clear coincident with an sbit beat.
    clr = 1'b1; idle(1); clr = 1'b0;
    for (int i = 0; i < 20; i++) drive_word(rand_data(), AW'(8'h80 + i), 1, 0, 0);
    idle(1);
    check("sat_sbit_cnt", sbit_cnt, CMAX);
    drive_word(rand_data(), 8'h77, 1, 0, 1);
    idle(1);
    check("clr_sbit_cnt", sbit_cnt, 1);
    check("clr_irq_sbit", irq_sbit, 1'b1);
    check("clr_log", {err_log_vld, err_log_addr, err_log_dbit}, {1'b1, 8'h77, 1'b0});

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = rand_data();
      in_addr     = AW'($urandom);
      in_sbit_err = ($urandom_range(0, 3) == 0);
      in_dbit_err = ($urandom_range(0, 7) == 0);
      clr         = ($urandom_range(0, 39) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step(acc);
    end
    clear_in();
    out_ready = 1'b1;
    idle(3);

    // Asynchronous reset while full with irqs set.
    out_ready = 1'b0;
    drive_word(rand_data(), 8'hA1, 0, 1, 0);
    drive_word(rand_data(), 8'hA2, 1, 0, 0);
    idle(1);
    check("pre_rst_in_ready", in_ready, 1'b0);
    check("pre_rst_irqs", {irq_sbit, irq_dbit}, 2'b11);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_cnts", {sbit_cnt, dbit_cnt}, 0);
    check("arst_log", {err_log_vld, err_log_addr, err_log_dbit}, 0);
    check("arst_irqs", {irq_sbit, irq_dbit}, 2'b00);
    check("arst_in_ready", in_ready, 1'b0);
    model_clear();
    out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    m_ready = 1'b1;
    drive_word(58'h0ABC, 8'h05, 0, 0, 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ecc_58_rd_check.md
Name: ecc_58_rd_check

Overview:
- Read-side check stage that sits directly downstream of the 58-bit SECDED decoder on the FIFO read path.
- Registers each corrected 58-bit data word together with its error flags, and presents it downstream over a valid/ready interface through a 2-entry skid buffer.
- Keeps saturating counts of single-bit and double-bit errors.
- Logs the address of the first error and raises sticky interrupts.

Parameters:
- DATA_WIDTH, 58, data word width; must match the decoder data width.
- ADDR_WIDTH, 8, FIFO read-address width that is logged on error.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a decoded word is present.
- in_ready  output  1  stage can accept a word.
- in_data  input  DATA_WIDTH  corrected data from the decoder.
- in_addr  input  ADDR_WIDTH  FIFO address the word was read from.
- in_sbit_err  input  1  decoder corrected a single-bit error.
- in_dbit_err  input  1  decoder detected an uncorrectable error.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_WIDTH  registered data.
- out_poison  output  1  word carried a double-bit error.
- clr  input  1  synchronous clear of counters, error log and interrupts.
- sbit_cnt  output  CNT_WIDTH  accepted single-bit error count, saturating.
- dbit_cnt  output  CNT_WIDTH  accepted double-bit error count, saturating.
- err_log_vld  output  1  error log holds an entry.
- err_log_addr  output  ADDR_WIDTH  address of the logged error.
- err_log_dbit  output  1  logged error is double-bit.
- irq_sbit  output  1  sticky single-bit interrupt.
- irq_dbit  output  1  sticky double-bit interrupt.

Behaviour:
- Reset: all outputs are 0. The buffer is EMPTY, so in_ready=0 during rst and in_ready=1 from the first cycle after rst deasserts.
- Accept: a transfer happens when in_valid & in_ready. Send: a transfer happens when out_valid & out_ready.
- Error class per accepted beat: dbit = in_dbit_err; sbit = in_sbit_err & ~in_dbit_err. When both flags are high, the beat counts as dbit only.
- Buffer FSM, states EMPTY / ONE / TWO. in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
  - EMPTY: on accept, go to ONE.
  - ONE: accept without send goes to TWO; send without accept goes to EMPTY; accept and send together stay in ONE with the new word.
  - TWO: on send, go to ONE and the skid entry moves to the output register. No accept is possible in TWO.
- Latency: 1 cycle from accept to out_valid when the buffer was EMPTY.
- Ordering is strictly FIFO. out_data and out_poison are stable while out_valid=1 and out_ready=0.
- out_poison = the dbit class of that same beat.
- Counters:
  - Increment only on accepted beats of the matching class. A stalled input that is not accepted never counts.
  - Each counter saturates at all-ones and holds there.
  - clr with no error in the same cycle sets the counter to 0. clr together with an accepted error of that class sets the counter to 1.
- Error log:
  - When err_log_vld=0, the first accepted sbit or dbit beat captures the address, sets err_log_dbit = dbit, and sets err_log_vld=1.
  - When err_log_vld=1 and err_log_dbit=0, an accepted dbit beat overwrites the address and sets err_log_dbit=1. This upgrade happens once.
  - When err_log_dbit=1, the log is frozen until clr.
  - clr coincident with an accepted error reloads the log with that beat.
- Interrupts:
  - irq_sbit and irq_dbit are set on the cycle after an accepted beat of their class and stay high until clr.
  - clr coincident with a new error of a class leaves that irq set.
- clr has no effect on buffer contents or handshake.
- rst mid-operation: buffered words are discarded; counters, log and irqs go to 0 immediately (asynchronous).

Test Plan:
- Reset then stream 4 clean words with out_ready=1 -> out_valid one cycle after each accept; data in order; counters 0; irqs 0; in_ready stays 1.
- out_ready=0, push 3 words -> first two accepted, in_ready=0 from the cycle after the second accept; third word held upstream. Raise out_ready -> words 1, 2, 3 out in order, no loss or duplication.
- Beat at addr 0x12 with sbit, then addr 0x34 with dbit, then addr 0x56 with dbit -> sbit_cnt=1, dbit_cnt=2, err_log_addr=0x34, err_log_dbit=1, irq_sbit=1, irq_dbit=1, out_poison=1 on the 2nd and 3rd words.
- Beat with in_sbit_err=in_dbit_err=1 -> dbit_cnt +1, sbit_cnt unchanged, out_poison=1.
- With CNT_WIDTH=4, send 20 sbit beats -> sbit_cnt holds 15. Then clr together with an sbit beat -> sbit_cnt=1, irq_sbit stays 1, err_log_vld=1 with that beat's address.
- Assert rst while the buffer is in TWO and irqs are set -> out_valid=0, all counters, log and irqs 0 immediately. in_ready=1 on the first cycle after release.
